// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the signals between the instruction fetch controller and its
// neighbours.
//   Memory side : mem_req / mem_addr go out, mem_ack / mem_rdata come back.
//   Execute side: redirect / redirect_pc come in.
//   Decode side : inst / inst_pc / inst_valid go out, inst_ready comes back.
// The master modport is the fetch controller. The slave modport is whatever
// sits around it: memory, execute and decode, or a testbench.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    modport master (
        output mem_req, mem_addr, inst, inst_pc, inst_valid,
        input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst, inst_pc, inst_valid,
        output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Single-outstanding-request instruction fetch controller.
// It issues word-aligned reads and holds the returned word for decode until
// decode accepts it. Control-flow redirects from execute are applied at any
// point in the flow. A read that has already been issued is never withdrawn.
// Its data is simply dropped when it returns.
// Ports:
//   clk    : single rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : fetch_ctrl_if.master (memory, redirect and decode handshakes)
// Parameter:
//   RESET_PC : first fetch address after reset; bits [1:0] are ignored
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          resetn,
    fetch_ctrl_if.master  bus
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h0000_0003;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        started_q, started_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = bus.redirect_pc & ~32'h0000_0003;

    // State register. started_q keeps the FSM in IDLE for one extra edge
    // after reset release. As a result the first request appears on the
    // second rising edge. An ack that shows up before then is never looked at.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            pc_q      <= RESET_PC_ALIGNED;
            addr_q    <= RESET_PC_ALIGNED;
            inst_q    <= NOP_INST;
            inst_pc_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // Next-state logic. pc_q is the address of the next fetch.
    // addr_q remembers the address of a request that was overtaken by a
    // redirect. That request stays on the bus, unchanged, until its ack.
    // Redirect is checked first in every state, so it wins over ack and ready.
    always_comb begin
        state_d   = state_q;
        started_d = 1'b1;
        pc_d      = pc_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        unique case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    pc_d = redirect_aligned;
                end
                if (started_q) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                if (bus.redirect) begin
                    pc_d = redirect_aligned;
                    if (bus.mem_ack) begin
                        state_d = REQ;
                    end else begin
                        addr_d  = pc_q;
                        state_d = DISCARD;
                    end
                end else if (bus.mem_ack) begin
                    inst_d    = bus.mem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                    state_d   = HOLD;
                end
            end

            HOLD: begin
                if (bus.redirect) begin
                    pc_d    = redirect_aligned;
                    state_d = REQ;
                end else if (bus.inst_ready) begin
                    state_d = REQ;
                end
            end

            DISCARD: begin
                if (bus.redirect) begin
                    pc_d = redirect_aligned;
                end
                if (bus.mem_ack) begin
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state. While a discarded request is pending,
    // the bus keeps showing that request's address, not the new pc.
    assign bus.mem_req    = (state_q == REQ) || (state_q == DISCARD);
    assign bus.mem_addr   = (state_q == DISCARD) ? addr_q : pc_q;
    assign bus.inst_valid = (state_q == HOLD);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed testbench for fetch_ctrl. A transaction-level model of the
// fetcher predicts the outputs, and these are compared on every falling
// edge. Hand-computed literal checks after each directed step pin the
// model's behaviour.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic clk;
    logic resetn;

    fetch_ctrl_if busIf ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (busIf.master)
    );

    int checkCount = 0;
    int failCount  = 0;

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the run must always come to an end on its own
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        failCount++;
        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison. A mismatch produces exactly one FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return just after the next rising edge
    task automatic applyStimulus(input logic redir, input logic [31:0] redirPc,
                                 input logic ack, input logic [31:0] rdata,
                                 input logic ready);
        busIf.redirect    = redir;
        busIf.redirect_pc = redirPc;
        busIf.mem_ack     = ack;
        busIf.mem_rdata   = rdata;
        busIf.inst_ready  = ready;
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model of the fetcher. It tracks:
    //   - whether a read is in flight, its address, and whether its data is
    //     already unwanted (a redirect overtook it);
    //   - the word parked for decode, if any;
    //   - the address that will be requested next.
    // After reset the first read is launched on the second clock edge.
    int          mBoot        = 0;
    bit          mOutstanding = 0;
    bit          mStale       = 0;
    logic [31:0] mOutAddr     = 32'h0;
    logic [31:0] mFetchPc     = 32'h0;
    bit          mHeld        = 0;
    logic [31:0] mHeldInst    = 32'h0000_0013;
    logic [31:0] mHeldPc      = 32'h0;

    always @(posedge clk or negedge resetn) begin
        logic [31:0] newPc;
        if (!resetn) begin
            mBoot        = 0;
            mOutstanding = 0;
            mStale       = 0;
            mOutAddr     = 32'h0;
            mFetchPc     = 32'h0;
            mHeld        = 0;
            mHeldInst    = 32'h0000_0013;
            mHeldPc      = 32'h0;
        end else begin
            newPc = busIf.redirect_pc & 32'hFFFF_FFFC;
            if (mBoot < 2) begin
                mBoot++;
                if (busIf.redirect) mFetchPc = newPc;
                if (mBoot == 2) begin
                    mOutstanding = 1;
                    mOutAddr     = mFetchPc;
                    mStale       = 0;
                end
            end else if (mOutstanding) begin
                if (busIf.mem_ack) begin
                    mOutstanding = 0;
                    if (!mStale && !busIf.redirect) begin
                        mHeld     = 1;
                        mHeldInst = busIf.mem_rdata;
                        mHeldPc   = mOutAddr;
                        mFetchPc  = mOutAddr + 32'd4;
                    end else begin
                        if (busIf.redirect) mFetchPc = newPc;
                        mOutstanding = 1;
                        mOutAddr     = mFetchPc;
                        mStale       = 0;
                    end
                end else if (busIf.redirect) begin
                    mFetchPc = newPc;
                    mStale   = 1;
                end
            end else if (mHeld) begin
                if (busIf.redirect || busIf.inst_ready) begin
                    if (busIf.redirect) mFetchPc = newPc;
                    mHeld        = 0;
                    mOutstanding = 1;
                    mOutAddr     = mFetchPc;
                    mStale       = 0;
                end
            end
        end
    end

    // Compare process: DUT against the model on every falling edge
    always @(negedge clk) begin
        checkOutput("cyc_mem_req",    {31'b0, busIf.mem_req},    {31'b0, mOutstanding});
        checkOutput("cyc_inst_valid", {31'b0, busIf.inst_valid}, {31'b0, mHeld});
        checkOutput("cyc_inst",       busIf.inst,                mHeldInst);
        checkOutput("cyc_inst_pc",    busIf.inst_pc,             mHeldPc);
        if (mOutstanding)
            checkOutput("cyc_mem_addr", busIf.mem_addr, mOutAddr);
    end

    // Directed sequence with hand-computed expectations
    initial begin
        resetn            = 1'b0;
        busIf.redirect    = 1'b0;
        busIf.redirect_pc = 32'h0;
        busIf.mem_ack     = 1'b0;
        busIf.mem_rdata   = 32'h0;
        busIf.inst_ready  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mem_req",    {31'b0, busIf.mem_req},    32'd0);
        checkOutput("rst_inst_valid", {31'b0, busIf.inst_valid}, 32'd0);
        checkOutput("rst_inst",       busIf.inst,                32'h0000_0013);
        checkOutput("rst_inst_pc",    busIf.inst_pc,             32'h0);
        checkOutput("rst_mem_addr",   busIf.mem_addr,            32'h0);
        resetn = 1'b1;

        // Boot: ack before the first request is ignored; request on 2nd edge
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("boot_edge1_req", {31'b0, busIf.mem_req}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("boot_edge2_req",  {31'b0, busIf.mem_req},    32'd1);
        checkOutput("boot_edge2_addr", busIf.mem_addr,            32'h0);
        checkOutput("boot_no_valid",   {31'b0, busIf.inst_valid}, 32'd0);

        // Immediate ack
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0093, 1'b0);
        checkOutput("ack0_valid", {31'b0, busIf.inst_valid}, 32'd1);
        checkOutput("ack0_inst",  busIf.inst,                32'h0000_0093);
        checkOutput("ack0_pc",    busIf.inst_pc,             32'h0);
        checkOutput("ack0_req",   {31'b0, busIf.mem_req},    32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("next_req",  {31'b0, busIf.mem_req}, 32'd1);
        checkOutput("next_addr", busIf.mem_addr,         32'h4);

        // Ack delayed 5 cycles
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            checkOutput("wait_req",   {31'b0, busIf.mem_req},    32'd1);
            checkOutput("wait_addr",  busIf.mem_addr,            32'h4);
            checkOutput("wait_valid", {31'b0, busIf.inst_valid}, 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0113, 1'b0);
        checkOutput("ack4_valid", {31'b0, busIf.inst_valid}, 32'd1);
        checkOutput("ack4_inst",  busIf.inst,                32'h0000_0113);
        checkOutput("ack4_pc",    busIf.inst_pc,             32'h4);

        // Held instruction is not taken for 4 cycles; stray acks are ignored
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'hBAD0_0000, 1'b0);
            checkOutput("hold_inst",  busIf.inst,                32'h0000_0113);
            checkOutput("hold_pc",    busIf.inst_pc,             32'h4);
            checkOutput("hold_req",   {31'b0, busIf.mem_req},    32'd0);
            checkOutput("hold_valid", {31'b0, busIf.inst_valid}, 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("accept_req",  {31'b0, busIf.mem_req}, 32'd1);
        checkOutput("accept_addr", busIf.mem_addr,         32'h8);

        // Redirect to 0x102 two cycles before the ack
        applyStimulus(1'b1, 32'h0000_0102, 1'b0, 32'h0, 1'b0);
        checkOutput("disc_addr0", busIf.mem_addr,         32'h8);
        checkOutput("disc_req0",  {31'b0, busIf.mem_req}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("disc_addr1", busIf.mem_addr, 32'h8);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hBAD0_0001, 1'b0);
        checkOutput("disc_drop",  {31'b0, busIf.inst_valid}, 32'd0);
        checkOutput("disc_req2",  {31'b0, busIf.mem_req},    32'd1);
        checkOutput("disc_new",   busIf.mem_addr,            32'h0000_0100);

        // Redirect and ack in the same REQ cycle
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 32'hBAD0_0002, 1'b0);
        checkOutput("same_drop", {31'b0, busIf.inst_valid}, 32'd0);
        checkOutput("same_addr", busIf.mem_addr,            32'h0000_0200);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0213, 1'b0);
        checkOutput("same_valid", {31'b0, busIf.inst_valid}, 32'd1);
        checkOutput("same_pc",    busIf.inst_pc,             32'h0000_0200);

        // Redirect in HOLD (with ready): valid falls, refetch at the target
        applyStimulus(1'b1, 32'h0000_0301, 1'b0, 32'h0, 1'b1);
        checkOutput("hredir_valid", {31'b0, busIf.inst_valid}, 32'd0);
        checkOutput("hredir_req",   {31'b0, busIf.mem_req},    32'd1);
        checkOutput("hredir_addr",  busIf.mem_addr,            32'h0000_0300);

        // Redirect in DISCARD overwrites the pending pc, also in the ack cycle
        applyStimulus(1'b1, 32'h0000_0400, 1'b0, 32'h0, 1'b0);
        checkOutput("dd_addr0", busIf.mem_addr, 32'h0000_0300);
        applyStimulus(1'b1, 32'h0000_0500, 1'b1, 32'hBAD0_0003, 1'b0);
        checkOutput("dd_addr1", busIf.mem_addr,            32'h0000_0500);
        checkOutput("dd_drop",  {31'b0, busIf.inst_valid}, 32'd0);

        // pc wrap at the top of the address space
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 32'hBAD0_0004, 1'b0);
        checkOutput("wrap_addr0", busIf.mem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0313, 1'b0);
        checkOutput("wrap_pc",    busIf.inst_pc,             32'hFFFF_FFFC);
        checkOutput("wrap_valid", {31'b0, busIf.inst_valid}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_req",   {31'b0, busIf.mem_req}, 32'd1);
        checkOutput("wrap_addr1", busIf.mem_addr,         32'h0);

        // Asynchronous reset in the middle of a request
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("arst_req",   {31'b0, busIf.mem_req},    32'd0);
        checkOutput("arst_valid", {31'b0, busIf.inst_valid}, 32'd0);
        checkOutput("arst_inst",  busIf.inst,                32'h0000_0013);
        checkOutput("arst_pc",    busIf.inst_pc,             32'h0);
        checkOutput("arst_addr",  busIf.mem_addr,            32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Restart after reset
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("re_edge1_req", {31'b0, busIf.mem_req}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("re_edge2_req",  {31'b0, busIf.mem_req}, 32'd1);
        checkOutput("re_edge2_addr", busIf.mem_addr,         32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0093, 1'b1);
        checkOutput("re_inst", busIf.inst, 32'h0000_0093);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("re_addr", busIf.mem_addr, 32'h4);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end

endmodule
